// File: rtl/seg7_display_scan_if.sv
// Display-side bundle of the seven-segment scanner: the word to show, the blank
// request, and the registered active-low anode/segment/decimal-point lines.
interface seg7_display_scan_if;
  logic [31:0] display;
  logic        blank;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  // master: the pipeline-side source of the value; slave: the scanner itself.
  modport master (output display, blank, input AN, SEG, DP);
  modport slave  (input display, blank, output AN, SEG, DP);
endinterface

// File: rtl/seg7_display_scan.sv
// 8-digit common-anode seven-segment scanner with a per-frame shadow of `display`.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_display_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 CLR,
  seg7_display_scan_if.slave   disp
);

  localparam int unsigned DIGITS = 8;

  typedef logic [2:0] dig_t;

  localparam dig_t        LAST_DIG = dig_t'(DIGITS - 1);
  localparam logic [23:0] DIV_LAST = 24'(SCAN_DIV - 1);

  logic [23:0] div_cnt_q, div_cnt_d;
  dig_t        dig_q, dig_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        tick;
  logic        wrap;
  dig_t        next_dig;
  logic [31:0] src_word;
  logic [3:0]  nibble;
  logic        lz_dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign tick     = (div_cnt_q == DIV_LAST);
  assign wrap     = tick && (dig_q == LAST_DIG);
  assign next_dig = dig_q + 3'd1;
  // At the wrap edge digit 0 must come from the word being latched, not the stale frame.
  assign src_word = wrap ? disp.display : shadow_q;
  assign nibble   = src_word[{next_dig, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  assign lz_dark = (next_dig != 3'd0) && ((src_word >> {next_dig, 2'b00}) == 32'd0);
`else
  assign lz_dark = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    div_cnt_d = tick ? 24'd0 : div_cnt_q + 24'd1;
    dig_d     = dig_q;
    shadow_d  = shadow_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (tick) begin
      dig_d = next_dig;
      an_d  = (disp.blank || lz_dark) ? 8'hFF : ~(8'b1 << next_dig);
      seg_d = hex_to_seg(nibble);
      if (wrap) shadow_d = disp.display;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (CLR) begin
      div_cnt_q <= 24'd0;
      dig_q     <= 3'd0;
      shadow_q  <= 32'd0;
      an_q      <= 8'b1111_1110;
      seg_q     <= 7'b1000000;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign disp.AN  = an_q;
  assign disp.SEG = seg_q;
  assign disp.DP  = 1'b1;

endmodule

// File: tb/tb_seg7_display_scan.sv
// Bench for seg7_display_scan: two instances (SCAN_DIV=4 and 1) checked against a
// cycle-count reference model, hand-written scan sequences and a vector table.
module tb_seg7_display_scan;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr4, clr1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seg7_display_scan_if if4();
  seg7_display_scan_if if1();

  seg7_display_scan #(.SCAN_DIV(4)) dut4 (.clk(clk), .CLR(clr4), .disp(if4));
  seg7_display_scan #(.SCAN_DIV(1)) dut1 (.clk(clk), .CLR(clr1), .disp(if1));

  // Reference model: cycles since reset, the word shown in the current frame,
  // and the blank request seen at the most recent digit change.
  int          m_n   [2];
  logic [31:0] m_word[2];
  logic        m_blk [2];
  int          m_div [2];
  logic [6:0]  seg_ref[16];

  typedef struct {
    logic [31:0] display;
    logic        blank;
    int          digit;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input int i, input logic [7:0] an, input logic [6:0] seg,
                             input logic dp);
    int          dig;
    logic [31:0] rest;
    logic [7:0]  e_an;
    dig  = (m_n[i] / m_div[i]) % 8;
    rest = m_word[i] >> (4 * dig);
    if (m_blk[i] || (LZ && dig > 0 && rest == 32'd0)) e_an = 8'hFF;
    else                                               e_an = ~(8'h01 << dig);
    check(i == 0 ? "model4_an" : "model1_an", 32'(an), 32'(e_an));
    check(i == 0 ? "model4_seg" : "model1_seg", 32'(seg), 32'(seg_ref[rest[3:0]]));
    check(i == 0 ? "model4_dp" : "model1_dp", 32'(dp), 32'd1);
  endtask

  task automatic model_edge(input int i, input logic clr_v, input logic [31:0] disp_v,
                            input logic blank_v);
    if (clr_v) begin
      m_n[i] = 0; m_word[i] = 32'd0; m_blk[i] = 1'b0;
    end else begin
      m_n[i]++;
      if (m_n[i] % m_div[i] == 0) begin
        m_blk[i] = blank_v;
        if (m_n[i] % (8 * m_div[i]) == 0) m_word[i] = disp_v;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, clr4, if4.display, if4.blank);
    model_edge(1, clr1, if1.display, if1.blank);
    @(negedge clk);
    model_check(0, if4.AN, if4.SEG, if4.DP);
    model_check(1, if1.AN, if1.SEG, if1.DP);
  endtask

  task automatic run(input int k);
    for (int c = 0; c < k; c++) step();
  endtask

  task automatic chk4(input string name, input logic [7:0] an, input logic [6:0] seg);
    check({name, "_an"}, 32'(if4.AN), 32'(an));
    check({name, "_seg"}, 32'(if4.SEG), 32'(seg));
  endtask

  function automatic vec_t mk(input logic [31:0] d, input logic b, input int dg,
                              input logic [7:0] an, input logic [6:0] seg);
    vec_t v;
    v.display = d; v.blank = b; v.digit = dg; v.exp_an = an; v.exp_seg = seg;
    return v;
  endfunction

  initial begin
    logic [7:0] an_k;
    logic [6:0] order_seg[8];

    seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001; seg_ref[2]  = 7'b0100100;
    seg_ref[3]  = 7'b0110000; seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
    seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000; seg_ref[8]  = 7'b0000000;
    seg_ref[9]  = 7'b0010000; seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
    seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001; seg_ref[14] = 7'b0000110;
    seg_ref[15] = 7'b0001110;
    m_div[0] = 4; m_div[1] = 1;
    m_n[0] = 0; m_n[1] = 0; m_word[0] = '0; m_word[1] = '0; m_blk[0] = 0; m_blk[1] = 0;

    vecs[0]  = mk(32'h76543210, 1'b0, 0, 8'hFE, 7'b1000000);
    vecs[1]  = mk(32'h76543210, 1'b0, 1, 8'hFD, 7'b1111001);
    vecs[2]  = mk(32'h76543210, 1'b0, 2, 8'hFB, 7'b0100100);
    vecs[3]  = mk(32'h76543210, 1'b0, 3, 8'hF7, 7'b0110000);
    vecs[4]  = mk(32'h76543210, 1'b0, 4, 8'hEF, 7'b0011001);
    vecs[5]  = mk(32'h76543210, 1'b0, 5, 8'hDF, 7'b0010010);
    vecs[6]  = mk(32'h76543210, 1'b0, 6, 8'hBF, 7'b0000010);
    vecs[7]  = mk(32'h76543210, 1'b0, 7, 8'h7F, 7'b1111000);
    vecs[8]  = mk(32'hFEDCBA98, 1'b0, 0, 8'hFE, 7'b0000000);
    vecs[9]  = mk(32'hFEDCBA98, 1'b0, 1, 8'hFD, 7'b0010000);
    vecs[10] = mk(32'hFEDCBA98, 1'b0, 2, 8'hFB, 7'b0001000);
    vecs[11] = mk(32'hFEDCBA98, 1'b0, 3, 8'hF7, 7'b0000011);
    vecs[12] = mk(32'hFEDCBA98, 1'b0, 4, 8'hEF, 7'b1000110);
    vecs[13] = mk(32'hFEDCBA98, 1'b0, 5, 8'hDF, 7'b0100001);
    vecs[14] = mk(32'hFEDCBA98, 1'b0, 6, 8'hBF, 7'b0000110);
    vecs[15] = mk(32'hFEDCBA98, 1'b0, 7, 8'h7F, 7'b0001110);
    vecs[16] = mk(32'h76543210, 1'b1, 2, 8'hFF, 7'b0100100);
    vecs[17] = mk(32'hFEDCBA98, 1'b1, 7, 8'hFF, 7'b0001110);
    vecs[18] = mk(32'h00000100, 1'b0, 2, 8'hFB, 7'b1111001);
    vecs[19] = mk(32'h00000100, 1'b0, 3, LZ ? 8'hFF : 8'hF7, 7'b1000000);

    order_seg[0] = 7'b0000000; order_seg[1] = 7'b1111000; order_seg[2] = 7'b0000010;
    order_seg[3] = 7'b0010010; order_seg[4] = 7'b0011001; order_seg[5] = 7'b0110000;
    order_seg[6] = 7'b0100100; order_seg[7] = 7'b1111001;

    // Reset with all-F display: outputs show "0" on digit 0 and the first frame shows shadow 0.
    clr4 = 1'b1; clr1 = 1'b1;
    if4.display = 32'hFFFF_FFFF; if4.blank = 1'b0;
    if1.display = 32'h0; if1.blank = 1'b0;
    run(2);
    chk4("reset", 8'hFE, 7'b1000000);
    check("reset_dp", 32'(if4.DP), 32'd1);
    clr4 = 1'b0; clr1 = 1'b0;
    if4.display = 32'h1234_5678;
    run(31);
    chk4("first_frame_d7", 8'h7F, 7'b1000000);

    // Latch and digit order after the first wrap.
    for (int k = 0; k < 8; k++) begin
      run(k == 0 ? 1 : 4);
      an_k = ~(8'h01 << k);
      chk4($sformatf("order_d%0d", k), an_k, order_seg[k]);
    end

    // Anti-tear: change the word while digit 3 is lit.
    run(16);
    chk4("tear_d3", 8'hF7, 7'b0010010);
    if4.display = 32'h0000_ABCD;
    run(4);  chk4("tear_d4", 8'hEF, 7'b0011001);
    run(4);  chk4("tear_d5", 8'hDF, 7'b0110000);
    run(4);  chk4("tear_d6", 8'hBF, 7'b0100100);
    run(4);  chk4("tear_d7", 8'h7F, 7'b1111001);
    run(4);  chk4("new_d0", 8'hFE, 7'b0100001);
    run(4);  chk4("new_d1", 8'hFD, 7'b1000110);
    run(4);  chk4("new_d2", 8'hFB, 7'b0000011);
    run(4);  chk4("new_d3", 8'hF7, 7'b0001000);
    run(4);  chk4("new_d4", LZ ? 8'hFF : 8'hEF, 7'b1000000);

    // Blank for one whole frame, then release; blank between ticks is ignored.
    run(15);
    if4.blank = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run(k == 0 ? 1 : 4);
      check($sformatf("blank_d%0d_an", k), 32'(if4.AN), 32'hFF);
    end
    run(3);
    if4.blank = 1'b0;
    run(1);  chk4("unblank_d0", 8'hFE, 7'b0100001);
    run(1);
    if4.blank = 1'b1;
    run(2);  check("blank_midtick_an", 32'(if4.AN), 32'hFE);
    if4.blank = 1'b0;
    run(1);  check("after_midtick_an", 32'(if4.AN), 32'hFD);

    // Leading zeros: 0xA5 then 0.
    if4.display = 32'h0000_00A5;
    run(28); chk4("lz_a5_d0", 8'hFE, 7'b0010010);
    run(4);  chk4("lz_a5_d1", 8'hFD, 7'b0001000);
    run(4);  chk4("lz_a5_d2", LZ ? 8'hFF : 8'hFB, 7'b1000000);
    if4.display = 32'h0;
    run(24); chk4("lz_zero_d0", 8'hFE, 7'b1000000);
    run(4);  chk4("lz_zero_d1", LZ ? 8'hFF : 8'hFD, 7'b1000000);

    // Vector table on the SCAN_DIV=1 instance: 8-cycle frame, digit per cycle.
    foreach (vecs[v]) begin
      clr1 = 1'b1;
      run(1);
      clr1 = 1'b0;
      if1.display = vecs[v].display;
      if1.blank   = vecs[v].blank;
      run(8 + vecs[v].digit);
      check($sformatf("vec%0d_an", v), 32'(if1.AN), 32'(vecs[v].exp_an));
      check($sformatf("vec%0d_seg", v), 32'(if1.SEG), 32'(vecs[v].exp_seg));
    end

    // CLR while digit 5 is lit restarts at digit 0 showing "0".
    if1.blank = 1'b0; if1.display = 32'h8765_4321;
    clr1 = 1'b1; run(1); clr1 = 1'b0;
    run(13);
    check("clr_mid_pre_an", 32'(if1.AN), 32'hDF);
    clr1 = 1'b1;
    run(1);
    check("clr_mid_an", 32'(if1.AN), 32'hFE);
    check("clr_mid_seg", 32'(if1.SEG), 32'(7'b1000000));
    clr1 = 1'b0;
    run(1);
    check("clr_mid_next_an", 32'(if1.AN), 32'hFD);
    check("clr_mid_next_seg", 32'(if1.SEG), 32'(7'b1000000));

    // Randomized phase, checked every cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(39) == 0) if4.display = $urandom;
      if ($urandom_range(39) == 0) if1.display = $urandom;
      if ($urandom_range(29) == 0) if4.blank = ~if4.blank;
      if ($urandom_range(29) == 0) if1.blank = ~if1.blank;
      if ($urandom_range(7) == 0)  if4.display = $urandom & 32'h0000_0FFF;
      clr4 = ($urandom_range(199) == 0);
      clr1 = ($urandom_range(199) == 0);
      run(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
